// File: rtl/dice_disp_pkg.sv
// Shared constants and state encoding for the DICE thread-ID dispatcher.
package dice_disp_pkg;

  localparam int unsigned NUM_TID             = 512;
  localparam int unsigned TID_WIDTH           = $clog2(NUM_TID);
  localparam int unsigned MAX_CGRA_PIPE_STAGE = 32;
  localparam int unsigned MAX_IO_PIPE_STAGE   = 8;
  localparam int unsigned DRAIN_WIDTH         = $clog2(MAX_CGRA_PIPE_STAGE + 2 * MAX_IO_PIPE_STAGE + 1);
  // Full-precision width of ntid_x*ntid_y*ntid_z.
  localparam int unsigned PROD_WIDTH          = 3 * TID_WIDTH;
  // Thread total must hold NUM_TID itself, one bit wider than a TID.
  localparam int unsigned TOTAL_WIDTH         = TID_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN
  } disp_state_e;

endpackage

// File: rtl/dice_tid_counter_3d.sv
// Nested x/y/z thread counter with a parallel linear count; no divider needed.
module dice_tid_counter_3d
  import dice_disp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_cnt,
  input  logic                 inc,
  input  logic [TID_WIDTH-1:0] ntid_x,
  input  logic [TID_WIDTH-1:0] ntid_y,
  input  logic [TID_WIDTH-1:0] ntid_z,
  output logic [TID_WIDTH-1:0] x,
  output logic [TID_WIDTH-1:0] y,
  output logic [TID_WIDTH-1:0] z,
  output logic [TID_WIDTH-1:0] cur
);

  // Advance x fastest, carrying into y and then z on each wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      x   <= '0;
      y   <= '0;
      z   <= '0;
      cur <= '0;
    end else if (inc) begin
      cur <= cur + TID_WIDTH'(1);
      if (x == ntid_x - TID_WIDTH'(1)) begin
        x <= '0;
        if (y == ntid_y - TID_WIDTH'(1)) begin
          y <= '0;
          if (z == ntid_z - TID_WIDTH'(1)) z <= '0;
          else                             z <= z + TID_WIDTH'(1);
        end else begin
          y <= y + TID_WIDTH'(1);
        end
      end else begin
        x <= x + TID_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/dice_tid_dispatcher.sv
// Issues one CTA's thread IDs in linear order, then waits out the pipeline drain.
module dice_tid_dispatcher
  import dice_disp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   start,
  input  logic [TID_WIDTH-1:0]   ntid_x,
  input  logic [TID_WIDTH-1:0]   ntid_y,
  input  logic [TID_WIDTH-1:0]   ntid_z,
  input  logic [NUM_TID-1:0]     active_mask,
  input  logic [DRAIN_WIDTH-1:0] drain_latency,
  input  logic                   disp_stall,
  output logic                   disp_valid,
  output logic [TID_WIDTH-1:0]   disp_tid,
  output logic [TID_WIDTH-1:0]   tid_x,
  output logic [TID_WIDTH-1:0]   tid_y,
  output logic [TID_WIDTH-1:0]   tid_z,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  disp_state_e            state;
  logic [TID_WIDTH-1:0]   lat_x, lat_y, lat_z;
  logic [DRAIN_WIDTH-1:0] drain_lat;
  logic [DRAIN_WIDTH-1:0] drain_cnt;
  logic [TOTAL_WIDTH-1:0] total;
  logic [TID_WIDTH-1:0]   cnt_x, cnt_y, cnt_z, cur;
  logic [PROD_WIDTH-1:0]  prod_c;
  logic                   last_c;
  logic                   inc_c;
  logic                   clr_cnt_c;

  assign prod_c    = PROD_WIDTH'(lat_x) * PROD_WIDTH'(lat_y) * PROD_WIDTH'(lat_z);
  assign last_c    = ({1'b0, cur} == total - TOTAL_WIDTH'(1));
  assign inc_c     = (state == ST_ISSUE) && !disp_stall;
  assign clr_cnt_c = clr || (state == ST_LOAD);

  dice_tid_counter_3d u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_cnt (clr_cnt_c),
    .inc     (inc_c),
    .ntid_x  (lat_x),
    .ntid_y  (lat_y),
    .ntid_z  (lat_z),
    .x       (cnt_x),
    .y       (cnt_y),
    .z       (cnt_z),
    .cur     (cur)
  );

  // Dispatcher FSM, drain counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state      <= ST_IDLE;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_z      <= '0;
      drain_lat  <= '0;
      drain_cnt  <= '0;
      total      <= '0;
      disp_valid <= 1'b0;
      disp_tid   <= '0;
      tid_x      <= '0;
      tid_y      <= '0;
      tid_z      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          disp_valid <= 1'b0;
          busy       <= 1'b0;
          // The completion cycle still counts as busy, so a start there is ignored.
          if (start && !done) begin
            lat_x     <= ntid_x;
            lat_y     <= ntid_y;
            lat_z     <= ntid_z;
            drain_lat <= drain_latency;
            cfg_err   <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (prod_c > PROD_WIDTH'(NUM_TID)) begin
            cfg_err <= 1'b1;
            total   <= TOTAL_WIDTH'(NUM_TID);
          end else begin
            total   <= TOTAL_WIDTH'(prod_c);
          end
          // An empty CTA skips ISSUE; the drain is shortened by the skipped ISSUE cycle.
          if (prod_c == '0) begin
            if (drain_lat == '0) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              drain_cnt <= drain_lat - DRAIN_WIDTH'(1);
              state     <= ST_DRAIN;
            end
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (disp_stall) begin
            disp_valid <= 1'b0;
          end else begin
            disp_valid <= active_mask[cur];
            disp_tid   <= cur;
            tid_x      <= cnt_x;
            tid_y      <= cnt_y;
            tid_z      <= cnt_z;
            if (last_c) begin
              drain_cnt <= drain_lat;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          disp_valid <= 1'b0;
          if (drain_cnt == '0) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
